ahb_master: RTL and testbench
=============================

# ahb_master

Command-driven AHB-lite initiator: turns single-transfer read/write commands from a local valid/ready port into AHB-lite NONSEQ transfers and returns one response per command, in order. It is the bus-side initiator that drives the team's AHB-lite slaves (RAM, peripherals) through the interconnect. It handles byte-lane steering, alignment checking and wait states, and optionally overlaps address and data phases.

## Interface
- AWIDTH, 8, address width in bits (HADDR_O and CMD_ADDR_I)
- HCLK_I  in  1  clock; all logic on rising edge
- HRESET_N_I  in  1  reset, synchronous, active-low
- CMD_VALID_I  in  1  command present
- CMD_READY_O  out  1  command accepted at edge when VALID&READY
- CMD_WRITE_I  in  1  1 = write, 0 = read
- CMD_SIZE_I  in  2  0 byte, 1 halfword, 2 word, 3 illegal
- CMD_ADDR_I  in  AWIDTH  byte address
- CMD_WDATA_I  in  32  write data, right-justified
- RSP_VALID_O  out  1  one-cycle response pulse
- RSP_RDATA_O  out  32  read data, right-justified, zero-extended; 0 for writes
- RSP_ERR_O  out  1  error (misaligned/illegal size, or HRESP ERROR)
- HADDR_O  out  AWIDTH  address phase address
- HTRANS_O  out  2  2'b00 IDLE, 2'b10 NONSEQ only
- HWRITE_O  out  1  address phase direction
- HSIZE_O  out  3  {1'b0, size}
- HWDATA_O  out  32  write data, driven during data phase
- HRDATA_I  in  32  read data, sampled at data phase completion
- HREADY_I  in  1  bus HREADY; phase completes at edge with HREADY_I=1
- HRESP_I  in  1  0 OKAY, 1 ERROR

## Operation
- Two slots: A (address phase, drives HADDR/HTRANS/HWRITE/HSIZE from registers) and D (data phase). Both empty after reset.
- At edge with HREADY_I=1: D retires (response generated), A moves to D, accepted command loads A.
- HTRANS_O = NONSEQ iff A valid, else IDLE; address outputs hold stable while HREADY_I=0.
- Alignment: halfword needs addr[0]=0, word needs addr[1:0]=0, size 3 illegal. Illegal command is accepted but never enters A; it produces RSP_VALID_O=1, RSP_ERR_O=1 in order behind any transfer still in flight (held in a one-entry error marker; CMD_READY_O low while marker set).
- Write lane steering: byte replicated on all four lanes, halfword on both halves, word as-is.
- Read extraction: lane selected by D's addr[1:0] and size, shifted to bits [7:0]/[15:0], zero-extended.
- HRESP_I=1 with HREADY_I=0 during data phase (first error cycle): next cycle HTRANS_O forced IDLE, A contents kept; A re-presented as NONSEQ after the error completes. Completing response carries RSP_ERR_O=1, RSP_RDATA_O=0.
- Reset mid-transfer: slots, marker and outputs cleared at the reset edge; in-flight transfer dropped, no response.

## Timing
- Reset values: CMD_READY_O=0 during reset, 1 the cycle after; RSP_VALID_O=0, RSP_RDATA_O=0, RSP_ERR_O=0, HTRANS_O=IDLE, HADDR_O=0, HWRITE_O=0, HSIZE_O=0, HWDATA_O=0.
- Zero wait states: accept at edge E0, NONSEQ in cycle after E0, data phase after E1, RSP_VALID_O=1 in cycle after E2 (3 cycles latency).
- Each HREADY_I=0 cycle in a phase adds one cycle.
- RSP outputs registered; RSP_VALID_O never high two cycles for one command.

## Configuration
- AHB_MASTER_PIPELINE_EN defined: CMD_READY_O = !A_valid | HREADY_I (combinational on HREADY_I); back-to-back commands give consecutive NONSEQ cycles, one transfer per cycle.
- Not defined: CMD_READY_O = !A_valid & !D_valid; A and D never both valid; one transfer per 3 cycles at zero wait states; no combinational path HREADY_I→CMD_READY_O.

## Test plan
- Reset with CMD_VALID_I=1 -> all outputs at reset values, no NONSEQ until one cycle after release.
- Word write 0xDEADBEEF to 0x10, then word read 0x10 against RAM model -> HWDATA_O=0xDEADBEEF in data phase, read RSP_RDATA_O=0xDEADBEEF, RSP_ERR_O=0, 3-cycle latency each.
- Byte write 0xA5 to 0x13, byte read 0x13 -> HSIZE_O=0, HWDATA_O=0xA5A5A5A5, RSP_RDATA_O=0x000000A5.
- Halfword read at 0x11 and size 3 -> RSP_ERR_O=1, HTRANS_O stays IDLE throughout.
- Two HREADY_I=0 cycles in data phase, then HRESP_I=1 two-cycle ERROR with next command pending -> latency 5 cycles, HTRANS_O IDLE in second error cycle, RSP_ERR_O=1, pending command then issued normally.
- With AHB_MASTER_PIPELINE_EN, four back-to-back word writes to 0x0,0x4,0x8,0xC -> four consecutive NONSEQ cycles, four consecutive RSP_VALID_O pulses in order; without macro -> NONSEQ every third cycle.

Source files
------------

// File: rtl/ahb_master_if.sv
// ahb_master_if: command/response port and AHB-lite bus signals of ahb_master.
// master is the initiator's view, slave is the view of whatever drives commands and models the bus.
interface ahb_master_if #(parameter int AWIDTH = 8);
  logic              CMD_VALID_I;
  logic              CMD_READY_O;
  logic              CMD_WRITE_I;
  logic [1:0]        CMD_SIZE_I;
  logic [AWIDTH-1:0] CMD_ADDR_I;
  logic [31:0]       CMD_WDATA_I;
  logic              RSP_VALID_O;
  logic [31:0]       RSP_RDATA_O;
  logic              RSP_ERR_O;
  logic [AWIDTH-1:0] HADDR_O;
  logic [1:0]        HTRANS_O;
  logic              HWRITE_O;
  logic [2:0]        HSIZE_O;
  logic [31:0]       HWDATA_O;
  logic [31:0]       HRDATA_I;
  logic              HREADY_I;
  logic              HRESP_I;
  modport master (
    input  CMD_VALID_I, CMD_WRITE_I, CMD_SIZE_I, CMD_ADDR_I, CMD_WDATA_I, HRDATA_I, HREADY_I, HRESP_I,
    output CMD_READY_O, RSP_VALID_O, RSP_RDATA_O, RSP_ERR_O, HADDR_O, HTRANS_O, HWRITE_O, HSIZE_O, HWDATA_O
  );
  modport slave (
    output CMD_VALID_I, CMD_WRITE_I, CMD_SIZE_I, CMD_ADDR_I, CMD_WDATA_I, HRDATA_I, HREADY_I, HRESP_I,
    input  CMD_READY_O, RSP_VALID_O, RSP_RDATA_O, RSP_ERR_O, HADDR_O, HTRANS_O, HWRITE_O, HSIZE_O, HWDATA_O
  );
endinterface

// File: rtl/ahb_master.sv
// ahb_master: command-driven AHB-lite initiator with address slot A and data slot D.
// Define AHB_MASTER_PIPELINE_EN to overlap address and data phases (one transfer per cycle).
module ahb_master #(parameter int AWIDTH = 8) (
  input logic          HCLK_I,
  input logic          HRESET_N_I,
  ahb_master_if.master bus
);
  logic              a_valid_q, a_valid_d, a_write_q, a_write_d;
  logic [1:0]        a_size_q, a_size_d;
  logic [AWIDTH-1:0] a_addr_q, a_addr_d;
  logic [31:0]       a_wdata_q, a_wdata_d;
  logic              d_valid_q, d_valid_d, d_write_q, d_write_d;
  logic [1:0]        d_size_q, d_size_d, d_lane_q, d_lane_d;
  logic [31:0]       hwdata_q, hwdata_d;
  logic              idle_q, idle_d, err_q, err_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              bad, load, move, retire, fire;
  logic [31:0]       steer, rd_shift, rd_data;
`ifdef AHB_MASTER_PIPELINE_EN
  assign bus.CMD_READY_O = HRESET_N_I & !err_q & (!a_valid_q | (bus.HREADY_I & !idle_q));
`else
  assign bus.CMD_READY_O = HRESET_N_I & !err_q & !a_valid_q & !d_valid_q;
`endif
  always_comb begin
    bad = (bus.CMD_SIZE_I == 2'd3) | ((bus.CMD_SIZE_I == 2'd1) & bus.CMD_ADDR_I[0])
        | ((bus.CMD_SIZE_I == 2'd2) & (|bus.CMD_ADDR_I[1:0]));
    load = bus.CMD_VALID_I & bus.CMD_READY_O & !bad;
    move = a_valid_q & !idle_q & bus.HREADY_I;
    retire = d_valid_q & bus.HREADY_I;
    fire = err_q & !a_valid_q & !d_valid_q;
    steer = (bus.CMD_SIZE_I == 2'd0) ? {4{bus.CMD_WDATA_I[7:0]}}
          : (bus.CMD_SIZE_I == 2'd1) ? {2{bus.CMD_WDATA_I[15:0]}} : bus.CMD_WDATA_I;
    a_valid_d = load | (a_valid_q & !move);
    a_write_d = load ? bus.CMD_WRITE_I : a_write_q;
    a_size_d = load ? bus.CMD_SIZE_I : a_size_q;
    a_addr_d = load ? bus.CMD_ADDR_I : a_addr_q;
    a_wdata_d = load ? steer : a_wdata_q;
    d_valid_d = move | (d_valid_q & !retire);
    d_write_d = move ? a_write_q : d_write_q;
    d_size_d = move ? a_size_q : d_size_q;
    d_lane_d = move ? a_addr_q[1:0] : d_lane_q;
    hwdata_d = move ? a_wdata_q : hwdata_q;
    // first ERROR cycle cancels the pending address phase until the error completes
    idle_d = retire ? 1'b0 : idle_q | (d_valid_q & bus.HRESP_I);
    err_d = (bus.CMD_VALID_I & bus.CMD_READY_O & bad) | (err_q & !fire);
    rd_shift = bus.HRDATA_I >> {d_lane_q, 3'b000};
    rd_data = (d_size_q == 2'd0) ? {24'd0, rd_shift[7:0]}
            : (d_size_q == 2'd1) ? {16'd0, rd_shift[15:0]} : rd_shift;
    rsp_valid_d = retire | fire;
    rsp_err_d = retire ? bus.HRESP_I : fire;
    rsp_rdata_d = (retire & !d_write_q & !bus.HRESP_I) ? rd_data : 32'd0;
  end
  always_ff @(posedge HCLK_I) begin
    if (!HRESET_N_I) begin
      a_valid_q <= 1'b0;
      a_write_q <= 1'b0;
      a_size_q <= 2'd0;
      a_addr_q <= '0;
      a_wdata_q <= 32'd0;
      d_valid_q <= 1'b0;
      d_write_q <= 1'b0;
      d_size_q <= 2'd0;
      d_lane_q <= 2'd0;
      hwdata_q <= 32'd0;
      idle_q <= 1'b0;
      err_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      a_valid_q <= a_valid_d;
      a_write_q <= a_write_d;
      a_size_q <= a_size_d;
      a_addr_q <= a_addr_d;
      a_wdata_q <= a_wdata_d;
      d_valid_q <= d_valid_d;
      d_write_q <= d_write_d;
      d_size_q <= d_size_d;
      d_lane_q <= d_lane_d;
      hwdata_q <= hwdata_d;
      idle_q <= idle_d;
      err_q <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
  assign bus.HADDR_O = a_addr_q;
  assign bus.HTRANS_O = (a_valid_q & !idle_q) ? 2'b10 : 2'b00;
  assign bus.HWRITE_O = a_write_q;
  assign bus.HSIZE_O = {1'b0, a_size_q};
  assign bus.HWDATA_O = hwdata_q;
  assign bus.RSP_VALID_O = rsp_valid_q;
  assign bus.RSP_RDATA_O = rsp_rdata_q;
  assign bus.RSP_ERR_O = rsp_err_q;
endmodule

// File: tb/tb_ahb_master.sv
// tb_ahb_master: directed bench for ahb_master against a byte-addressed AHB-lite RAM slave.
module tb_ahb_master;
  logic clk, rst_n, rdy_s;
  int n_cmp, n_bad, cyc;
  logic mon_en;
  int ns_q[$], rsp_q[$];
  logic [7:0] mem [256];
  logic dp_v, dp_w;
  logic [1:0] dp_sz;
  logic [7:0] dp_a;
  ahb_master_if #(.AWIDTH(8)) bus();
  ahb_master #(.AWIDTH(8)) dut(.HCLK_I(clk), .HRESET_N_I(rst_n), .bus(bus.master));
`ifdef AHB_MASTER_PIPELINE_EN
  localparam int GAP = 1, LAT2 = 2;
`else
  localparam int GAP = 3, LAT2 = 3;
`endif
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // RAM slave: captures address phase, writes enabled lanes at OKAY completion
  always @(posedge clk) begin
    if (!rst_n) begin
      dp_v <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
    end else if (bus.HREADY_I) begin
      if (dp_v && dp_w && !bus.HRESP_I)
        for (int b = 0; b < 4; b++)
          if (dp_sz == 2'd2 || (dp_sz == 2'd1 && b[1] == dp_a[1]) || (dp_sz == 2'd0 && b[1:0] == dp_a[1:0]))
            mem[{dp_a[7:2], b[1:0]}] <= bus.HWDATA_O[8*b +: 8];
      dp_v <= bus.HTRANS_O == 2'b10;
      dp_a <= bus.HADDR_O;
      dp_w <= bus.HWRITE_O;
      dp_sz <= bus.HSIZE_O[1:0];
    end
  end
  assign bus.HRDATA_I = {mem[{dp_a[7:2], 2'd3}], mem[{dp_a[7:2], 2'd2}], mem[{dp_a[7:2], 2'd1}], mem[{dp_a[7:2], 2'd0}]};
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mon_en && bus.HTRANS_O == 2'b10) ns_q.push_back(cyc);
    if (mon_en && bus.RSP_VALID_O) rsp_q.push_back(cyc);
  end
  task automatic tick(input logic hr, input logic hp);
    @(negedge clk);
    if (bus.CMD_VALID_I && rdy_s) bus.CMD_VALID_I = 1'b0;
    bus.HREADY_I = hr;
    bus.HRESP_I = hp;
    #1 rdy_s = bus.CMD_READY_O;
  endtask
  task automatic put(input logic w, input logic [1:0] sz, input logic [7:0] ad, input logic [31:0] wd);
    bus.CMD_WRITE_I = w;
    bus.CMD_SIZE_I = sz;
    bus.CMD_ADDR_I = ad;
    bus.CMD_WDATA_I = wd;
    bus.CMD_VALID_I = 1'b1;
  endtask
  task automatic do_cmd(input logic w, input logic [1:0] sz, input logic [7:0] ad, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er, output logic [31:0] hw2,
                        output logic [2:0] hs1, output int ns, output logic dbl);
    int n;
    logic got;
    tick(1'b1, 1'b0);
    put(w, sz, ad, wd);
    n = 0;
    while (!rdy_s && n < 20) begin tick(1'b1, 1'b0); n++; end
    lat = 0; ns = 0; got = 1'b0; rd = 32'hx; er = 1'bx; hw2 = 32'h0; hs1 = 3'h7;
    while (!got && lat < 20) begin
      tick(1'b1, 1'b0);
      lat++;
      if (bus.HTRANS_O == 2'b10) ns++;
      if (lat == 1) hs1 = bus.HSIZE_O;
      if (lat == 2) hw2 = bus.HWDATA_O;
      if (bus.RSP_VALID_O) begin got = 1'b1; rd = bus.RSP_RDATA_O; er = bus.RSP_ERR_O; end
    end
    tick(1'b1, 1'b0);
    dbl = bus.RSP_VALID_O;
  endtask
  task automatic test_reset;
    put(1'b0, 2'd2, 8'h00, 32'h0);
    repeat (3) tick(1'b1, 1'b0);
    n_cmp++; if (rdy_s !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", rdy_s); end
    n_cmp++; if (bus.HTRANS_O !== 2'b00) begin n_bad++; $display("FAIL rst_htrans: got %b want 00", bus.HTRANS_O); end
    n_cmp++; if (bus.HADDR_O !== 8'h00) begin n_bad++; $display("FAIL rst_haddr: got %h want 00", bus.HADDR_O); end
    n_cmp++; if (bus.HWRITE_O !== 1'b0) begin n_bad++; $display("FAIL rst_hwrite: got %b want 0", bus.HWRITE_O); end
    n_cmp++; if (bus.HSIZE_O !== 3'd0) begin n_bad++; $display("FAIL rst_hsize: got %h want 0", bus.HSIZE_O); end
    n_cmp++; if (bus.HWDATA_O !== 32'h0) begin n_bad++; $display("FAIL rst_hwdata: got %h want 0", bus.HWDATA_O); end
    n_cmp++; if ({bus.RSP_VALID_O, bus.RSP_ERR_O, bus.RSP_RDATA_O} !== 34'h0) begin n_bad++;
      $display("FAIL rst_rsp: got v=%b e=%b d=%h want all 0", bus.RSP_VALID_O, bus.RSP_ERR_O, bus.RSP_RDATA_O); end
    tick(1'b1, 1'b0);
    rst_n = 1'b1;
    #1 rdy_s = bus.CMD_READY_O;
    n_cmp++; if (rdy_s !== 1'b1) begin n_bad++; $display("FAIL rel_ready: got %b want 1", rdy_s); end
    n_cmp++; if (bus.HTRANS_O !== 2'b00) begin n_bad++; $display("FAIL rel_htrans: got %b want 00", bus.HTRANS_O); end
    tick(1'b1, 1'b0);
    n_cmp++; if (bus.HTRANS_O !== 2'b10) begin n_bad++; $display("FAIL rel_nonseq: got %b want 10", bus.HTRANS_O); end
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    n_cmp++; if (bus.RSP_VALID_O !== 1'b1 || bus.RSP_RDATA_O !== 32'h03020100) begin n_bad++;
      $display("FAIL rel_read: got v=%b d=%h want v=1 d=03020100", bus.RSP_VALID_O, bus.RSP_RDATA_O); end
  endtask
  task automatic test_reset_mid;
    tick(1'b1, 1'b0);
    put(1'b0, 2'd2, 8'h04, 32'h0);
    tick(1'b1, 1'b0);
    rst_n = 1'b0;
    tick(1'b1, 1'b0);
    n_cmp++; if (bus.HTRANS_O !== 2'b00 || bus.HADDR_O !== 8'h00 || rdy_s !== 1'b0) begin n_bad++;
      $display("FAIL mid_rst_clear: got trans=%b addr=%h rdy=%b want 00/00/0", bus.HTRANS_O, bus.HADDR_O, rdy_s); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0);
      n_cmp++; if (bus.RSP_VALID_O !== 1'b0) begin n_bad++; $display("FAIL mid_rst_norsp: got %b want 0", bus.RSP_VALID_O); end
    end
  endtask
  task automatic test_word;
    int lat, ns; logic [31:0] rd, hw2; logic er, dbl; logic [2:0] hs1;
    do_cmd(1'b1, 2'd2, 8'h10, 32'hDEADBEEF, lat, rd, er, hw2, hs1, ns, dbl);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
    n_cmp++; if (hw2 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_hwdata: got %h want deadbeef", hw2); end
    n_cmp++; if (er !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL wr_rsp: got e=%b d=%h want 0/0", er, rd); end
    n_cmp++; if (dbl !== 1'b0) begin n_bad++; $display("FAIL wr_single_pulse: got %b want 0", dbl); end
    do_cmd(1'b0, 2'd2, 8'h10, 32'h0, lat, rd, er, hw2, hs1, ns, dbl);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_bad++; $display("FAIL rd_word: got d=%h e=%b want deadbeef/0", rd, er); end
    n_cmp++; if (hs1 !== 3'd2) begin n_bad++; $display("FAIL rd_hsize: got %h want 2", hs1); end
  endtask
  task automatic test_byte;
    int lat, ns; logic [31:0] rd, hw2; logic er, dbl; logic [2:0] hs1;
    do_cmd(1'b1, 2'd0, 8'h13, 32'h123456A5, lat, rd, er, hw2, hs1, ns, dbl);
    n_cmp++; if (hs1 !== 3'd0) begin n_bad++; $display("FAIL bwr_hsize: got %h want 0", hs1); end
    n_cmp++; if (hw2 !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL bwr_hwdata: got %h want a5a5a5a5", hw2); end
    do_cmd(1'b0, 2'd0, 8'h13, 32'h0, lat, rd, er, hw2, hs1, ns, dbl);
    n_cmp++; if (rd !== 32'h000000A5 || er !== 1'b0) begin n_bad++; $display("FAIL brd_data: got d=%h e=%b want 000000a5/0", rd, er); end
    do_cmd(1'b0, 2'd1, 8'h12, 32'h0, lat, rd, er, hw2, hs1, ns, dbl);
    n_cmp++; if (rd !== 32'h0000A5AD) begin n_bad++; $display("FAIL hrd_data: got %h want 0000a5ad", rd); end
    do_cmd(1'b1, 2'd1, 8'h22, 32'hFFFF1234, lat, rd, er, hw2, hs1, ns, dbl);
    n_cmp++; if (hw2 !== 32'h12341234) begin n_bad++; $display("FAIL hwr_hwdata: got %h want 12341234", hw2); end
  endtask
  task automatic test_illegal;
    int lat, ns; logic [31:0] rd, hw2; logic er, dbl; logic [2:0] hs1;
    do_cmd(1'b0, 2'd1, 8'h11, 32'h0, lat, rd, er, hw2, hs1, ns, dbl);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL misalign_rsp: got e=%b d=%h want 1/0", er, rd); end
    n_cmp++; if (ns !== 0) begin n_bad++; $display("FAIL misalign_idle: got %0d nonseq want 0", ns); end
    do_cmd(1'b1, 2'd3, 8'h00, 32'h0, lat, rd, er, hw2, hs1, ns, dbl);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL size3_err: got %b want 1", er); end
    n_cmp++; if (ns !== 0) begin n_bad++; $display("FAIL size3_idle: got %0d nonseq want 0", ns); end
    n_cmp++; if (dbl !== 1'b0) begin n_bad++; $display("FAIL size3_single_pulse: got %b want 0", dbl); end
  endtask
  task automatic test_error;
    int n;
    tick(1'b1, 1'b0);
    put(1'b0, 2'd2, 8'h20, 32'h0);
    tick(1'b1, 1'b0);
    put(1'b0, 2'd2, 8'h10, 32'h0);
    n_cmp++; if (bus.HTRANS_O !== 2'b10 || bus.HADDR_O !== 8'h20) begin n_bad++;
      $display("FAIL err_addr_phase: got trans=%b addr=%h want 10/20", bus.HTRANS_O, bus.HADDR_O); end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    n_cmp++; if (bus.HTRANS_O !== 2'b00) begin n_bad++; $display("FAIL err_idle: got %b want 00", bus.HTRANS_O); end
    n_cmp++; if (bus.RSP_VALID_O !== 1'b0) begin n_bad++; $display("FAIL err_early_rsp: got %b want 0", bus.RSP_VALID_O); end
    tick(1'b1, 1'b0);
    n_cmp++; if (bus.RSP_VALID_O !== 1'b1 || bus.RSP_ERR_O !== 1'b1 || bus.RSP_RDATA_O !== 32'h0) begin n_bad++;
      $display("FAIL err_rsp: got v=%b e=%b d=%h want 1/1/0", bus.RSP_VALID_O, bus.RSP_ERR_O, bus.RSP_RDATA_O); end
    n = 0;
    do begin tick(1'b1, 1'b0); n++; end while (!bus.RSP_VALID_O && n < 10);
    n_cmp++; if (n !== LAT2) begin n_bad++; $display("FAIL err_next_lat: got %0d want %0d", n, LAT2); end
    n_cmp++; if (bus.RSP_RDATA_O !== 32'hA5ADBEEF || bus.RSP_ERR_O !== 1'b0) begin n_bad++;
      $display("FAIL err_next_rsp: got d=%h e=%b want a5adbeef/0", bus.RSP_RDATA_O, bus.RSP_ERR_O); end
  endtask
  task automatic test_back_to_back;
    int lat, ns, n; logic [31:0] rd, hw2; logic er, dbl; logic [2:0] hs1;
    ns_q.delete(); rsp_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0);
      put(1'b1, 2'd2, 8'(4 * i), 32'h11111111 * (i + 1));
      n = 0;
      while (!rdy_s && n < 10) begin tick(1'b1, 1'b0); n++; end
    end
    repeat (8) tick(1'b1, 1'b0);
    mon_en = 1'b0;
    n_cmp++; if (ns_q.size() !== 4 || rsp_q.size() !== 4) begin n_bad++;
      $display("FAIL b2b_counts: got %0d nonseq %0d rsp want 4/4", ns_q.size(), rsp_q.size()); end
    for (int i = 1; i < 4; i++) begin
      n_cmp++; if (ns_q[i] - ns_q[i-1] !== GAP) begin n_bad++; $display("FAIL b2b_nonseq_gap%0d: got %0d want %0d", i, ns_q[i] - ns_q[i-1], GAP); end
      n_cmp++; if (rsp_q[i] - rsp_q[i-1] !== GAP) begin n_bad++; $display("FAIL b2b_rsp_gap%0d: got %0d want %0d", i, rsp_q[i] - rsp_q[i-1], GAP); end
    end
    n_cmp++; if (rsp_q[0] - ns_q[0] !== 2) begin n_bad++; $display("FAIL b2b_first_lat: got %0d want 2", rsp_q[0] - ns_q[0]); end
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b0, 2'd2, 8'(4 * i), 32'h0, lat, rd, er, hw2, hs1, ns, dbl);
      n_cmp++; if (rd !== 32'h11111111 * (i + 1)) begin n_bad++; $display("FAIL b2b_readback%0d: got %h want %h", i, rd, 32'h11111111 * (i + 1)); end
    end
  endtask
  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; mon_en = 1'b0;
    rst_n = 1'b0; rdy_s = 1'b0;
    bus.CMD_VALID_I = 1'b0; bus.CMD_WRITE_I = 1'b0; bus.CMD_SIZE_I = 2'd0;
    bus.CMD_ADDR_I = 8'h0; bus.CMD_WDATA_I = 32'h0;
    bus.HREADY_I = 1'b1; bus.HRESP_I = 1'b0;
    test_reset;
    test_reset_mid;
    test_word;
    test_byte;
    test_illegal;
    test_error;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
